vga_timing_gen: RTL and testbench

Generates the VGA raster timing for the Go Board video path: horizontal and vertical pixel counters, sync pulses, a visible-area flag, and frame/line start strobes. It sits directly upstream of the per-pixel generators, which consume `o_hpos`, `o_vpos` and `o_visible` and return colour. An optional delay line realigns sync and visible with pipelined downstream pixel stages.

---
 rtl/vga_timing_gen_pkg.sv | 33 +++
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_timing_gen_sync_delay.sv | 27 ++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Defaults are 640x480@60 with a 25 MHz pixel clock.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [CNT_W-1:0] cnt_t;

  // Signals carried through the realignment delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
  } sync_bits_t;

  function automatic int axis_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the per-pixel generators.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  cnt_t o_hpos;
  cnt_t o_vpos;
  logic o_visible;
  logic o_hsync;
  logic o_vsync;
  logic o_line_start;
  logic o_frame_start;
  logic o_hsync_d;
  logic o_vsync_d;
  logic o_visible_d;

  modport master (
    output o_hpos, o_vpos, o_visible, o_hsync, o_vsync,
           o_line_start, o_frame_start, o_hsync_d, o_vsync_d, o_visible_d
  );

  modport slave (
    input o_hpos, o_vpos, o_visible, o_hsync, o_vsync,
          o_line_start, o_frame_start, o_hsync_d, o_vsync_d, o_visible_d
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// DEPTH-stage shift register realigning hsync/vsync/visible with pipelined pixel stages.
module vga_timing_gen_sync_delay
  import vga_timing_gen_pkg::*;
#(
  parameter int         DEPTH    = 1,
  parameter sync_bits_t RST_BITS = '0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  sync_bits_t i_bits,
  output sync_bits_t o_bits
);

  sync_bits_t r_sr [DEPTH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_BITS;
    end else begin
      r_sr[0] <= i_bits;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_bits = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered syncs, visible flag and start strobes,
// plus an optional delayed copy of sync/visible for pipelined pixel generators.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int SYNC_ACTIVE = 0,
  parameter int SYNC_DELAY  = 0
) (
  input logic              i_clk,
  input logic              i_reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS_C  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS_C  = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_FIRST = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_LAST  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_LAST  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);
  localparam logic       SYNC_OFF = ~SYNC_ON;
  localparam sync_bits_t RST_BITS = '{hsync: SYNC_OFF, vsync: SYNC_OFF, visible: 1'b0};

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
  end

  logic       r_running;
  cnt_t       r_hpos;
  cnt_t       r_vpos;
  logic       r_visible;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_line_start;
  logic       r_frame_start;
  cnt_t       w_hpos_nxt;
  cnt_t       w_vpos_nxt;
  sync_bits_t w_now;
  sync_bits_t w_dly;

  // The first cycle after reset release presents (0,0) rather than advancing from it.
  always_comb begin
    w_hpos_nxt = r_hpos;
    w_vpos_nxt = r_vpos;
    if (!r_running) begin
      w_hpos_nxt = '0;
      w_vpos_nxt = '0;
    end else if (r_hpos == H_LAST) begin
      w_hpos_nxt = '0;
      w_vpos_nxt = (r_vpos == V_LAST) ? '0 : r_vpos + cnt_t'(1);
    end else begin
      w_hpos_nxt = r_hpos + cnt_t'(1);
    end
  end

  // Decodes use the next counter values so every output register moves with the counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_running     <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_visible     <= 1'b0;
      r_hsync       <= SYNC_OFF;
      r_vsync       <= SYNC_OFF;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_running     <= 1'b1;
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_visible     <= (w_hpos_nxt < H_VIS_C) && (w_vpos_nxt < V_VIS_C);
      r_hsync       <= (w_hpos_nxt >= HS_FIRST && w_hpos_nxt <= HS_LAST) ? SYNC_ON : SYNC_OFF;
      r_vsync       <= (w_vpos_nxt >= VS_FIRST && w_vpos_nxt <= VS_LAST) ? SYNC_ON : SYNC_OFF;
      r_line_start  <= (w_hpos_nxt == '0);
      r_frame_start <= (w_hpos_nxt == '0) && (w_vpos_nxt == '0);
    end
  end

  assign w_now = '{hsync: r_hsync, vsync: r_vsync, visible: r_visible};

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign w_dly = w_now;
  end else begin : g_delay
    vga_timing_gen_sync_delay #(
      .DEPTH    (SYNC_DELAY),
      .RST_BITS (RST_BITS)
    ) u_sync_delay (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_bits  (w_now),
      .o_bits  (w_dly)
    );
  end

  assign vga.o_hpos        = r_hpos;
  assign vga.o_vpos        = r_vpos;
  assign vga.o_visible     = r_visible;
  assign vga.o_hsync       = r_hsync;
  assign vga.o_vsync       = r_vsync;
  assign vga.o_line_start  = r_line_start;
  assign vga.o_frame_start = r_frame_start;
  assign vga.o_hsync_d     = w_dly.hsync;
  assign vga.o_vsync_d     = w_dly.vsync;
  assign vga.o_visible_d   = w_dly.visible;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640x480 instance with a 2-clock delay line and a 15x7 instance
// without one, both checked every clock against a raster model driven by elapsed cycles.
module tb_vga_timing_gen;

  // Instance A: default timing, SYNC_DELAY=2. Instance B: tiny raster, SYNC_DELAY=0.
  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2, A_VB = 33, A_DLY = 2;
  localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 4, B_VF = 1, B_VS = 1, B_VB = 1, B_DLY = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen #(
    .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
    .SYNC_ACTIVE(0), .SYNC_DELAY(A_DLY)
  ) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .vga     (if_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .SYNC_ACTIVE(0), .SYNC_DELAY(B_DLY)
  ) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .vga     (if_b)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model state: whether each raster runs, and clocks elapsed since its first active cycle.
  bit         run_m [2];
  int         t_m   [2];
  logic [2:0] hist_a [$];   // {hsync, vsync, visible} history, newest last
  logic [2:0] hist_b [$];
  int         last_ls [2];
  int         last_fs [2];
  int         ls_in_frame [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int ht(input int k);
    return (k == 0) ? (A_HV + A_HF + A_HS + A_HB) : (B_HV + B_HF + B_HS + B_HB);
  endfunction

  function automatic int vt(input int k);
    return (k == 0) ? (A_VV + A_VF + A_VS + A_VB) : (B_VV + B_VF + B_VS + B_VB);
  endfunction

  // Expected raster outputs of instance k from elapsed time alone.
  task automatic model_now(input int k, output int h, output int v, output logic vis,
                           output logic hs, output logic vs, output logic ls, output logic fs);
    int hv, hf, hsw, vv, vf, vsw;
    hv  = (k == 0) ? A_HV : B_HV;  hf = (k == 0) ? A_HF : B_HF;  hsw = (k == 0) ? A_HS : B_HS;
    vv  = (k == 0) ? A_VV : B_VV;  vf = (k == 0) ? A_VF : B_VF;  vsw = (k == 0) ? A_VS : B_VS;
    if (!run_m[k]) begin
      h = 0; v = 0; vis = 1'b0; hs = 1'b1; vs = 1'b1; ls = 1'b0; fs = 1'b0;
    end else begin
      h   = t_m[k] % ht(k);
      v   = (t_m[k] / ht(k)) % vt(k);
      vis = (h < hv) && (v < vv);
      hs  = (h >= hv + hf && h < hv + hf + hsw) ? 1'b0 : 1'b1;
      vs  = (v >= vv + vf && v < vv + vf + vsw) ? 1'b0 : 1'b1;
      ls  = (h == 0);
      fs  = (h == 0) && (v == 0);
    end
  endtask

  task automatic hist_fill_idle();
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i < 8; i++) begin
      hist_a.push_back(3'b110);
      hist_b.push_back(3'b110);
    end
  endtask

  task automatic hist_push();
    int h, v;
    logic vis, hs, vs, ls, fs;
    for (int k = 0; k < 2; k++) begin
      model_now(k, h, v, vis, hs, vs, ls, fs);
      if (k == 0) begin
        hist_a.push_back({hs, vs, vis});
        if (hist_a.size() > 8) void'(hist_a.pop_front());
      end else begin
        hist_b.push_back({hs, vs, vis});
        if (hist_b.size() > 8) void'(hist_b.pop_front());
      end
    end
  endtask

  task automatic reset_events();
    for (int k = 0; k < 2; k++) begin
      last_ls[k] = -1;
      last_fs[k] = -1;
      ls_in_frame[k] = 0;
    end
  endtask

  // Rising-edge bookkeeping for the model.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run_m[k] = 1'b0;
      end else if (!run_m[k]) begin
        run_m[k] = 1'b1;
        t_m[k]   = 0;
      end else begin
        t_m[k]++;
      end
    end
    hist_push();
  endtask

  task automatic check_all();
    int h, v;
    logic vis, hs, vs, ls, fs;
    logic [2:0] d_exp;
    logic [9:0] o_h, o_v;
    logic o_vis, o_hs, o_vs, o_ls, o_fs, o_hsd, o_vsd, o_visd;
    string n;
    for (int k = 0; k < 2; k++) begin
      model_now(k, h, v, vis, hs, vs, ls, fs);
      if (k == 0) begin
        n = "a";
        d_exp = hist_a[hist_a.size() - 1 - A_DLY];
        o_h = if_a.o_hpos; o_v = if_a.o_vpos; o_vis = if_a.o_visible;
        o_hs = if_a.o_hsync; o_vs = if_a.o_vsync; o_ls = if_a.o_line_start; o_fs = if_a.o_frame_start;
        o_hsd = if_a.o_hsync_d; o_vsd = if_a.o_vsync_d; o_visd = if_a.o_visible_d;
      end else begin
        n = "b";
        d_exp = hist_b[hist_b.size() - 1 - B_DLY];
        o_h = if_b.o_hpos; o_v = if_b.o_vpos; o_vis = if_b.o_visible;
        o_hs = if_b.o_hsync; o_vs = if_b.o_vsync; o_ls = if_b.o_line_start; o_fs = if_b.o_frame_start;
        o_hsd = if_b.o_hsync_d; o_vsd = if_b.o_vsync_d; o_visd = if_b.o_visible_d;
      end
      chk({n, "_hpos"}, 32'(o_h), 32'(h));
      chk({n, "_vpos"}, 32'(o_v), 32'(v));
      chk({n, "_visible"}, 32'(o_vis), 32'(vis));
      chk({n, "_hsync"}, 32'(o_hs), 32'(hs));
      chk({n, "_vsync"}, 32'(o_vs), 32'(vs));
      chk({n, "_line_start"}, 32'(o_ls), 32'(ls));
      chk({n, "_frame_start"}, 32'(o_fs), 32'(fs));
      chk({n, "_hsync_d"}, 32'(o_hsd), 32'(d_exp[2]));
      chk({n, "_vsync_d"}, 32'(o_vsd), 32'(d_exp[1]));
      chk({n, "_visible_d"}, 32'(o_visd), 32'(d_exp[0]));
      // Strobe spacing, measured on what the DUT actually emits.
      if (o_ls === 1'b1) begin
        if (last_ls[k] >= 0) chk({n, "_line_period"}, 32'(cyc - last_ls[k]), 32'(ht(k)));
        last_ls[k] = cyc;
        if (o_fs === 1'b1) begin
          if (last_fs[k] >= 0) begin
            chk({n, "_frame_period"}, 32'(cyc - last_fs[k]), 32'(ht(k) * vt(k)));
            chk({n, "_lines_per_frame"}, 32'(ls_in_frame[k]), 32'(vt(k)));
          end
          last_fs[k] = cyc;
          ls_in_frame[k] = 1;
        end else begin
          ls_in_frame[k]++;
        end
      end else if (o_fs === 1'b1) begin
        chk({n, "_frame_without_line"}, 32'(o_ls), 32'(1));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  // Called right after a negedge check: asserts reset between edges and expects an immediate effect.
  task automatic async_reset(input int hold);
    #2;
    rst = 1'b1;
    #1;
    run_m[0] = 1'b0;
    run_m[1] = 1'b0;
    hist_fill_idle();
    reset_events();
    check_all();
    repeat (hold) step();
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    run_m[0] = 1'b0;
    run_m[1] = 1'b0;
    t_m[0] = 0;
    t_m[1] = 0;
    hist_fill_idle();
    reset_events();

    // Reset held for five clocks.
    rst = 1'b1;
    repeat (5) step();

    // Release and run past the first line wrap of the large raster.
    rst = 1'b0;
    repeat (850 + $urandom_range(0, 100)) step();

    // Reset mid-line at hpos 300.
    guard = 0;
    while (!(run_m[0] && (t_m[0] % ht(0)) == 300) && guard < 2000) begin
      step();
      guard++;
    end
    chk("reach_hpos_300", 32'(guard < 2000), 32'(1));
    async_reset(2);
    repeat (40) step();

    // Randomly placed reset pulses.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(20, 600)) step();
      async_reset($urandom_range(1, 4));
    end

    // Long enough for several complete frames of the small raster and a full line of the large one.
    repeat (900) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
